// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package lsm_pkg;

  localparam int LSM_DATA_W = 32;
  localparam int LSM_REG_AW = 4;
  localparam int LSM_NREGS  = 16;
  localparam int LSM_CNT_W  = 5;
  localparam int ADDR_STEP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2
  } lsm_state_e;

  function automatic logic [LSM_CNT_W-1:0] popcount(input logic [LSM_NREGS-1:0] v);
    logic [LSM_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LSM_NREGS; i++) c = c + {{(LSM_CNT_W-1){1'b0}}, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_lsb_encoder.sv
// Lowest-set-bit encoder: index of the lowest set bit, plus whether it is the only one left.
module lsb_encoder #(
  parameter int NREGS  = 16,
  parameter int REG_AW = 4
) (
  input  logic [NREGS-1:0]  list,
  output logic [REG_AW-1:0] idx,
  output logic              valid,
  output logic              last
);

  always_comb begin
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list[i]) idx = REG_AW'(i);
    end
    valid = |list;
    // An empty list also counts as last so the N=0 case exits in one cycle.
    last  = (list & (list - NREGS'(1))) == '0;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one register per cycle, optional base writeback.
// Optional illegal-form flag on err is built when LSM_ERR_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; all strobes low
// XFER    | one register transfer per cycle, lowest remaining register first
// WB      | final base written to base_reg, done pulses
module ldm_stm_sequencer
  import lsm_pkg::*;
#(
  parameter int DATA_W = LSM_DATA_W,
  parameter int REG_AW = LSM_REG_AW,
  parameter int NREGS  = LSM_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [NREGS-1:0]  reg_list,
  input  logic [REG_AW-1:0] base_reg,
  input  logic [DATA_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_AW-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [REG_AW-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              err
);

  lsm_state_e        state_q, state_d;
  logic [NREGS-1:0]  list_q;
  logic [DATA_W-1:0] addr_q, final_q;
  logic [REG_AW-1:0] base_reg_q;
  logic              is_load_q, wb_en_q;

  logic [REG_AW-1:0]    k_idx;
  logic                 k_valid, k_last;
  logic [LSM_CNT_W-1:0] n_regs;
  logic [DATA_W-1:0]    span, step, start_addr, final_base;
  logic                 take;

  lsb_encoder #(.NREGS(NREGS), .REG_AW(REG_AW)) u_enc (
    .list  (list_q),
    .idx   (k_idx),
    .valid (k_valid),
    .last  (k_last)
  );

  always_comb begin
    n_regs = popcount(reg_list);
    step   = DATA_W'(ADDR_STEP);
    span   = DATA_W'(n_regs) * step;
    take   = start && (state_q == ST_IDLE);
    if (up) start_addr = pre ? base_addr + step : base_addr;
    else    start_addr = pre ? base_addr - span : base_addr - span + step;
    final_base = up ? base_addr + span : base_addr - span;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take) state_d = ST_XFER;
      ST_XFER: if (k_last) state_d = wb_en_q ? ST_WB : ST_IDLE;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A loaded base register takes priority over the writeback value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      base_reg_q <= '0;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
    end else if (take) begin
      list_q     <= reg_list;
      addr_q     <= start_addr;
      final_q    <= final_base;
      base_reg_q <= base_reg;
      is_load_q  <= is_load;
      wb_en_q    <= wback && !(is_load && reg_list[base_reg]) && (n_regs != '0);
    end else if (state_q == ST_XFER) begin
      list_q <= list_q & (list_q - NREGS'(1));
      addr_q <= addr_q + step;
    end
  end

  always_comb begin
    busy          = start || (state_q != ST_IDLE);
    done          = 1'b0;
    mem_addr      = '0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    rf_read_addr  = '0;
    rf_write_addr = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    case (state_q)
      ST_XFER: begin
        done = k_last && !wb_en_q;
        if (k_valid) begin
          mem_addr = addr_q;
          if (is_load_q) begin
            mem_re        = 1'b1;
            rf_write_addr = k_idx;
            rf_write_data = mem_rdata;
            rf_reg_write  = 1'b1;
          end else begin
            mem_we       = 1'b1;
            rf_read_addr = k_idx;
            mem_wdata    = rf_read_data;
          end
        end
      end
      ST_WB: begin
        done          = 1'b1;
        rf_write_addr = base_reg_q;
        rf_write_data = final_q;
        rf_reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef LSM_ERR_CHECK_EN
  logic             err_q, bad;
  logic [NREGS-1:0] lowest, higher;

  always_comb begin
    lowest = reg_list & (~reg_list + NREGS'(1));
    higher = reg_list & ~lowest;
    bad    = (n_regs == '0) || (!is_load && wback && higher[base_reg]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      err_q <= 1'b0;
    else if (take) err_q <= bad;
  end

  assign err = done && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer; memory and register file are simple address-derived models.
module tb_ldm_stm_sequencer;

  localparam logic [31:0] PC_VAL   = 32'h0000_8008;
  localparam logic [31:0] MEM_XOR  = 32'h5A5A_0000;
`ifdef LSM_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk, rst, start, is_load, up, pre, wback;
  logic [15:0] reg_list;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic        busy, done, mem_re, mem_we, rf_reg_write, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_read_data, rf_write_data;
  logic [3:0]  rf_read_addr, rf_write_addr;

  int vectors = 0;
  int miscompares = 0;

  ldm_stm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .wback(wback), .reg_list(reg_list), .base_reg(base_reg), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata    = mem_addr ^ MEM_XOR;
  assign rf_read_data = (rf_read_addr == 4'd15) ? PC_VAL : (32'hC0DE_0000 | {28'd0, rf_read_addr});

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic l, input logic u, input logic p, input logic w,
                             input logic [15:0] lst, input logic [3:0] br, input logic [31:0] ba);
    is_load = l; up = u; pre = p; wback = w;
    reg_list = lst; base_reg = br; base_addr = ba;
    start = 1'b1;
  endtask

  task automatic test_reset;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 ||
        rf_reg_write !== 1'b0 || mem_addr !== 32'h0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b re=%b we=%b rfw=%b addr=%h err=%b, required all 0",
               busy, done, mem_re, mem_we, rf_reg_write, mem_addr, err);
    end
  endtask

  task automatic test_ldmia;
    logic [31:0] a;
    drive_start(1, 1, 0, 1, 16'h000F, 4'd13, 32'h100);
    next_cycle;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      a = 32'h100 + 32'(4 * (c - 1));
      vectors++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a || rf_reg_write !== 1'b1 ||
          rf_write_addr !== 4'(c - 1) || rf_write_data !== (a ^ MEM_XOR) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL ldmia_xfer%0d: re=%b addr=%h rfw=%b waddr=%0d wdata=%h done=%b, required re=1 addr=%h waddr=%0d wdata=%h done=0",
                 c, mem_re, mem_addr, rf_reg_write, rf_write_addr, rf_write_data, done, a, c - 1, a ^ MEM_XOR);
      end
      next_cycle;
    end
    vectors++;
    if (rf_reg_write !== 1'b1 || rf_write_addr !== 4'd13 || rf_write_data !== 32'h110 ||
        done !== 1'b1 || mem_re !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL ldmia_wb: rfw=%b waddr=%0d wdata=%h done=%b re=%b err=%b, required 1 13 00000110 1 0 0",
               rf_reg_write, rf_write_addr, rf_write_data, done, mem_re, err);
    end
    next_cycle;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL ldmia_idle: busy=%b done=%b rfw=%b, required 0 0 0", busy, done, rf_reg_write);
    end
  endtask

  task automatic test_stmdb;
    drive_start(0, 0, 1, 1, 16'h4010, 4'd2, 32'h200);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stmdb_busy0: busy=%b, required 1", busy);
    end
    next_cycle;
    start = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || rf_reg_write !== 1'b0 || mem_addr !== 32'h1F8 ||
        rf_read_addr !== 4'd4 || mem_wdata !== 32'hC0DE_0004 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stmdb_xfer1: we=%b addr=%h raddr=%0d wdata=%h busy=%b, required 1 000001f8 4 c0de0004 1",
               mem_we, mem_addr, rf_read_addr, mem_wdata, busy);
    end
    next_cycle;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1FC || rf_read_addr !== 4'd14 ||
        mem_wdata !== 32'hC0DE_000E || done !== 1'b0) begin
      miscompares++;
      $display("FAIL stmdb_xfer2: we=%b addr=%h raddr=%0d wdata=%h done=%b, required 1 000001fc 14 c0de000e 0",
               mem_we, mem_addr, rf_read_addr, mem_wdata, done);
    end
    next_cycle;
    vectors++;
    if (mem_we !== 1'b0 || rf_reg_write !== 1'b1 || rf_write_addr !== 4'd2 ||
        rf_write_data !== 32'h1F8 || done !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL stmdb_wb: we=%b rfw=%b waddr=%0d wdata=%h done=%b busy=%b err=%b, required 0 1 2 000001f8 1 1 0",
               mem_we, rf_reg_write, rf_write_addr, rf_write_data, done, busy, err);
    end
    next_cycle;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stmdb_busy_end: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_ldmib_base_in_list;
    drive_start(1, 1, 1, 1, 16'h0022, 4'd5, 32'h40);
    next_cycle;
    start = 1'b0;
    vectors++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h44 || rf_write_addr !== 4'd1 ||
        rf_write_data !== 32'h5A5A_0044 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ldmib_xfer1: re=%b addr=%h waddr=%0d wdata=%h done=%b, required 1 00000044 1 5a5a0044 0",
               mem_re, mem_addr, rf_write_addr, rf_write_data, done);
    end
    next_cycle;
    vectors++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h48 || rf_write_addr !== 4'd5 ||
        rf_write_data !== 32'h5A5A_0048 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL ldmib_xfer2: re=%b addr=%h waddr=%0d wdata=%h done=%b, required 1 00000048 5 5a5a0048 1",
               mem_re, mem_addr, rf_write_addr, rf_write_data, done);
    end
    next_cycle;
    vectors++;
    if (rf_reg_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ldmib_no_wb: rfw=%b busy=%b done=%b, required 0 0 0", rf_reg_write, busy, done);
    end
  endtask

  task automatic test_r15;
    drive_start(1, 1, 0, 0, 16'h8001, 4'd7, 32'h300);
    next_cycle;
    start = 1'b0;
    vectors++;
    if (rf_reg_write !== 1'b1 || rf_write_addr !== 4'd0 || rf_write_data !== 32'h5A5A_0300) begin
      miscompares++;
      $display("FAIL r15_ld_r0: rfw=%b waddr=%0d wdata=%h, required 1 0 5a5a0300",
               rf_reg_write, rf_write_addr, rf_write_data);
    end
    next_cycle;
    vectors++;
    if (rf_reg_write !== 1'b1 || rf_write_addr !== 4'd15 || mem_addr !== 32'h304 ||
        rf_write_data !== 32'h5A5A_0304 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL r15_ld_pc: rfw=%b waddr=%0d addr=%h wdata=%h done=%b, required 1 15 00000304 5a5a0304 1",
               rf_reg_write, rf_write_addr, mem_addr, rf_write_data, done);
    end
    next_cycle;
    drive_start(0, 0, 0, 0, 16'h8000, 4'd3, 32'h400);
    next_cycle;
    start = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h400 || rf_read_addr !== 4'd15 ||
        mem_wdata !== PC_VAL || done !== 1'b1 || rf_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL r15_stmda: we=%b addr=%h raddr=%0d wdata=%h done=%b rfw=%b, required 1 00000400 15 %h 1 0",
               mem_we, mem_addr, rf_read_addr, mem_wdata, done, rf_reg_write, PC_VAL);
    end
    next_cycle;
  endtask

  task automatic test_empty_list;
    drive_start(1, 1, 0, 1, 16'h0000, 4'd3, 32'h700);
    next_cycle;
    start = 1'b0;
    vectors++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || rf_reg_write !== 1'b0 || done !== 1'b1 ||
        busy !== 1'b1 || err !== ERR_EN) begin
      miscompares++;
      $display("FAIL empty_list: re=%b we=%b rfw=%b done=%b busy=%b err=%b, required 0 0 0 1 1 %b",
               mem_re, mem_we, rf_reg_write, done, busy, err, ERR_EN);
    end
    next_cycle;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_list_end: busy=%b done=%b rfw=%b, required 0 0 0", busy, done, rf_reg_write);
    end
  endtask

  task automatic test_stm_base_not_lowest;
    drive_start(0, 1, 0, 1, 16'h0003, 4'd1, 32'h600);
    next_cycle;
    start = 1'b0;
    next_cycle;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h604 || rf_read_addr !== 4'd1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL stm_base_xfer2: we=%b addr=%h raddr=%0d done=%b, required 1 00000604 1 0",
               mem_we, mem_addr, rf_read_addr, done);
    end
    next_cycle;
    vectors++;
    if (rf_reg_write !== 1'b1 || rf_write_addr !== 4'd1 || rf_write_data !== 32'h608 ||
        done !== 1'b1 || err !== ERR_EN) begin
      miscompares++;
      $display("FAIL stm_base_wb: rfw=%b waddr=%0d wdata=%h done=%b err=%b, required 1 1 00000608 1 %b",
               rf_reg_write, rf_write_addr, rf_write_data, done, err, ERR_EN);
    end
    next_cycle;
  endtask

  task automatic test_start_ignored;
    drive_start(1, 1, 0, 0, 16'h0003, 4'd9, 32'h500);
    next_cycle;
    reg_list = 16'hFFFF;
    is_load = 1'b0;
    vectors++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h500 || rf_write_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL busy_start1: re=%b addr=%h waddr=%0d, required 1 00000500 0",
               mem_re, mem_addr, rf_write_addr);
    end
    next_cycle;
    start = 1'b0;
    vectors++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h504 || rf_write_addr !== 4'd1 ||
        done !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start2: re=%b we=%b addr=%h waddr=%0d done=%b, required 1 0 00000504 1 1",
               mem_re, mem_we, mem_addr, rf_write_addr, done);
    end
    next_cycle;
    vectors++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_end: busy=%b we=%b re=%b, required 0 0 0", busy, mem_we, mem_re);
    end
  endtask

  task automatic test_reset_mid_op;
    drive_start(1, 1, 0, 1, 16'h000F, 4'd13, 32'h100);
    next_cycle;
    start = 1'b0;
    next_cycle;
    vectors++;
    if (mem_addr !== 32'h104 || rf_write_addr !== 4'd1 || rf_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: addr=%h waddr=%0d rfw=%b, required 00000104 1 1",
               mem_addr, rf_write_addr, rf_reg_write);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || mem_re !== 1'b0 || rf_reg_write !== 1'b0 || done !== 1'b0 ||
        mem_addr !== 32'h0 || rf_write_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_now: busy=%b re=%b rfw=%b done=%b addr=%h waddr=%0d, required all 0",
               busy, mem_re, rf_reg_write, done, mem_addr, rf_write_addr);
    end
    next_cycle;
    next_cycle;
    vectors++;
    if (rf_reg_write !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_wb: rfw=%b done=%b, required 0 0", rf_reg_write, done);
    end
    rst = 1'b1;
    test_ldmia();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    reg_list = '0; base_reg = '0; base_addr = '0;
    next_cycle;
    test_reset();
    next_cycle;
    rst = 1'b1;
    next_cycle;
    test_ldmia();
    test_stmdb();
    test_ldmib_base_in_list();
    test_r15();
    test_empty_list();
    test_stm_base_not_lowest();
    test_start_ignored();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
